// File: rtl/clock_pkg.sv
// Shared calendar constants and BCD digit helpers for the time/date counters.
package clock_pkg;

  localparam int SEC_MAX    = 59;
  localparam int MIN_MAX    = 59;
  localparam int HOUR_MAX   = 23;
  localparam int MON_MAX    = 12;
  localparam int DAY_MAX_28 = 28;
  localparam int DAY_MAX_29 = 29;
  localparam int DAY_MAX_30 = 30;
  localparam int DAY_MAX_31 = 31;

  typedef logic [3:0] bcd_t;

  function automatic bcd_t bcd_ones_of(int unsigned v);
    return bcd_t'(v % 10);
  endfunction

  function automatic bcd_t bcd_tens_of(int unsigned v);
    return bcd_t'((v / 10) % 10);
  endfunction

endpackage

// File: rtl/bin2bcd_split.sv
// Combinational binary to two-digit BCD split; present only when MOD_COUNTER_BCD_EN is defined.
`ifdef MOD_COUNTER_BCD_EN
module bin2bcd_split
  import clock_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] bin,
  output bcd_t             tens,
  output bcd_t             ones
);

  assign tens = bcd_tens_of(32'(bin));
  assign ones = bcd_ones_of(32'(bin));

endmodule
`endif

// File: rtl/mod_counter_n.sv
// Up/down modulo counter with runtime maximum, clamped preset and wrap pulses.
// Optional BCD outputs are enabled with the macro MOD_COUNTER_BCD_EN.
module mod_counter_n
  import clock_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int MIN_VAL = 0,
  parameter int DEF_MAX = 59
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] data,
  output logic             carry,
  output logic             borrow,
  output logic [WIDTH-1:0] max_q,
  output logic             at_max
`ifdef MOD_COUNTER_BCD_EN
  ,
  output bcd_t             bcd_tens,
  output bcd_t             bcd_ones
`endif
);

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] DEF_W = WIDTH'(DEF_MAX);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  logic [WIDTH-1:0] data_nxt;
  logic             carry_nxt;
  logic             borrow_nxt;
  logic             range_bad;

  assign range_bad = (max_val < MIN_W);
  assign at_max    = (data == max_val);

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    data_nxt   = data;
    carry_nxt  = 1'b0;
    borrow_nxt = 1'b0;
    if (load) begin
      if (range_bad)               data_nxt = MIN_W;
      else if (load_val < MIN_W)   data_nxt = MIN_W;
      else if (load_val > max_val) data_nxt = max_val;
      else                         data_nxt = load_val;
    end else if (en) begin
      if (range_bad) begin
        data_nxt = MIN_W;
      end else if (up) begin
        // >= also catches a count left above a freshly shrunk maximum
        if (data >= max_val) begin
          data_nxt  = MIN_W;
          carry_nxt = 1'b1;
        end else begin
          data_nxt = data + ONE_W;
        end
      end else begin
        if (data <= MIN_W) begin
          data_nxt   = max_val;
          borrow_nxt = 1'b1;
        end else if (data > max_val) begin
          data_nxt = max_val;
        end else begin
          data_nxt = data - ONE_W;
        end
      end
    end
  end

`ifdef MOD_COUNTER_BCD_EN
  bcd_t tens_nxt;
  bcd_t ones_nxt;

  bin2bcd_split #(
    .WIDTH (WIDTH)
  ) u_bin2bcd_split (
    .bin  (data_nxt),
    .tens (tens_nxt),
    .ones (ones_nxt)
  );
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      data   <= MIN_W;
      carry  <= 1'b0;
      borrow <= 1'b0;
      max_q  <= DEF_W;
`ifdef MOD_COUNTER_BCD_EN
      bcd_tens <= bcd_tens_of(MIN_VAL);
      bcd_ones <= bcd_ones_of(MIN_VAL);
`endif
    end else begin
      data   <= data_nxt;
      carry  <= carry_nxt;
      borrow <= borrow_nxt;
      max_q  <= max_val;
`ifdef MOD_COUNTER_BCD_EN
      bcd_tens <= tens_nxt;
      bcd_ones <= ones_nxt;
`endif
    end
  end

endmodule
